// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus of the integer register file with scoreboard.
// The master is the pipeline (decode + writeback); the slave is the register file.
interface reg_file_sb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    // decode read ports
    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic            rs1_busy;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            rs2_busy;

    // decode issue (marks destination busy)
    logic            issue_en;
    logic [AW-1:0]   issue_rd;

    // writeback port (writes data, clears busy)
    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;

    // raw registered busy bits
    logic [NREG-1:0] busy_vec;

    modport master (
        output rs1_addr, rs2_addr, issue_en, issue_rd, wb_en, wb_rd, wb_data,
        input  rs1_data, rs1_busy, rs2_data, rs2_busy, busy_vec
    );

    modport slave (
        input  rs1_addr, rs2_addr, issue_en, issue_rd, wb_en, wb_rd, wb_data,
        output rs1_data, rs1_busy, rs2_data, rs2_busy, busy_vec
    );
endinterface

// File: rtl/reg_file_sb.sv
// Integer register file (x0 hardwired to zero) with a pending-write scoreboard.
// Two combinational read ports with same-cycle writeback bypass, one write port,
// one busy bit per register set at issue and cleared at writeback.

// One read port: x0 -> 0, else bypass writeback, else stored value.
// Busy is masked when the same-cycle writeback satisfies the hazard.
module reg_file_sb_rdport #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            i_rst,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_wb_en,
    input  logic [AW-1:0]   i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic [XLEN-1:0] i_reg_data,
    input  logic            i_reg_busy,
    output logic [XLEN-1:0] o_data,
    output logic            o_busy
);
    logic w_hit;

    // reset gates the bypass so the port reads 0 while reset is held
    assign w_hit = !i_rst && i_wb_en && (i_wb_rd == i_addr);

    // read mux with bypass priority over storage
    always_comb begin
        o_data = '0;
        o_busy = 1'b0;
        if (!i_rst && (i_addr != '0)) begin
            o_data = w_hit ? i_wb_data : i_reg_data;
            o_busy = i_reg_busy && !w_hit;
        end
    end
endmodule

module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_sb_if.slave bus
);
    localparam int AW    = $clog2(NREG);
    localparam int NPORT = 2;

    // entry 0 is never written, so it stays at its reset value and folds away
    logic [NREG-1:0][XLEN-1:0]  r_regs;
    logic [NREG-1:0]            r_busy;
    logic [NREG-1:0]            w_busy_nxt;
    logic                       w_wr;
    logic                       w_set;

    logic [NPORT-1:0][AW-1:0]   w_rd_addr;
    logic [NPORT-1:0][XLEN-1:0] w_rd_data;
    logic [NPORT-1:0]           w_rd_busy;

    assign w_wr  = bus.wb_en    && (bus.wb_rd    != '0);
    assign w_set = bus.issue_en && (bus.issue_rd != '0);

    // architectural storage: writeback port, x0 writes dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regs <= '0;
        end else if (w_wr) begin
            r_regs[bus.wb_rd] <= bus.wb_data;
        end
    end

    // scoreboard next state: clear on writeback, then set on issue so a new
    // producer to the same register stays outstanding
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr)  w_busy_nxt[bus.wb_rd]    = 1'b0;
        if (w_set) w_busy_nxt[bus.issue_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign w_rd_addr[0] = bus.rs1_addr;
    assign w_rd_addr[1] = bus.rs2_addr;

    for (genvar p = 0; p < NPORT; p++) begin : g_rd
        reg_file_sb_rdport #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rd (
            .i_rst      (reset),
            .i_addr     (w_rd_addr[p]),
            .i_wb_en    (bus.wb_en),
            .i_wb_rd    (bus.wb_rd),
            .i_wb_data  (bus.wb_data),
            .i_reg_data (r_regs[w_rd_addr[p]]),
            .i_reg_busy (r_busy[w_rd_addr[p]]),
            .o_data     (w_rd_data[p]),
            .o_busy     (w_rd_busy[p])
        );
    end

    assign bus.rs1_data = w_rd_data[0];
    assign bus.rs1_busy = w_rd_busy[0];
    assign bus.rs2_data = w_rd_data[1];
    assign bus.rs2_busy = w_rd_busy[1];
    assign bus.busy_vec = r_busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, x0, bypass, scoreboard lifecycle,
// simultaneous set/clear and a full issue/writeback sweep.
module tb_reg_file_sb;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    reg_file_sb_if #(.XLEN(32), .NREG(32)) bus ();

    reg_file_sb #(.XLEN(32), .NREG(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_en    = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.issue_en = 1'b0;
        bus.issue_rd = '0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        idle();
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        #2;
        chk("rst_rs1_data", bus.rs1_data, 32'h0);
        chk("rst_rs2_data", bus.rs2_data, 32'h0);
        chk("rst_busy", {30'h0, bus.rs1_busy, bus.rs2_busy}, 32'h0);
        chk("rst_busy_vec", bus.busy_vec, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // reset test: x5 written and issued, then reset between edges
        bus.wb_en = 1'b1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF;
        bus.issue_en = 1'b1; bus.issue_rd = 5;
        tick();
        idle();
        bus.rs1_addr = 5;
        #1;
        chk("x5_written", bus.rs1_data, 32'hDEADBEEF);
        chk("x5_busy_vec", bus.busy_vec, 32'h0000_0020);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_data", bus.rs1_data, 32'h0);
        chk("async_rst_busy_vec", bus.busy_vec, 32'h0);
        // writeback and issue are ignored and bypass disabled under reset
        bus.wb_en = 1'b1; bus.wb_rd = 5; bus.wb_data = 32'h11111111;
        bus.issue_en = 1'b1; bus.issue_rd = 6;
        #1;
        chk("rst_no_bypass", bus.rs1_data, 32'h0);
        tick();
        chk("rst_ignore_busy", bus.busy_vec, 32'h0);
        #2;
        reset = 1'b0;
        idle();
        #1;
        chk("post_rst_x5", bus.rs1_data, 32'h0);

        // x0 writes and issues are dropped
        tick();
        bus.wb_en = 1'b1; bus.wb_rd = 0; bus.wb_data = 32'h12345678;
        bus.issue_en = 1'b1; bus.issue_rd = 0;
        bus.rs1_addr = 0;
        #1;
        chk("x0_bypass", bus.rs1_data, 32'h0);
        chk("x0_busy_comb", {31'h0, bus.rs1_busy}, 32'h0);
        tick();
        idle();
        #1;
        chk("x0_data", bus.rs1_data, 32'h0);
        chk("x0_busy_vec", bus.busy_vec, 32'h0);

        // bypass then storage
        bus.wb_en = 1'b1; bus.wb_rd = 7; bus.wb_data = 32'hA5A5A5A5;
        bus.rs1_addr = 7; bus.rs2_addr = 7;
        #1;
        chk("byp_rs1", bus.rs1_data, 32'hA5A5A5A5);
        chk("byp_rs2", bus.rs2_data, 32'hA5A5A5A5);
        tick();
        idle();
        #1;
        chk("store_rs1", bus.rs1_data, 32'hA5A5A5A5);
        chk("store_rs2", bus.rs2_data, 32'hA5A5A5A5);

        // scoreboard lifecycle on x3
        bus.issue_en = 1'b1; bus.issue_rd = 3;
        tick();
        idle();
        bus.rs2_addr = 3;
        #1;
        chk("sb_rs2_busy", {31'h0, bus.rs2_busy}, 32'h1);
        chk("sb_busy_vec_set", bus.busy_vec, 32'h0000_0008);
        tick();
        chk("sb_busy_hold", {31'h0, bus.rs2_busy}, 32'h1);
        bus.wb_en = 1'b1; bus.wb_rd = 3; bus.wb_data = 32'h55;
        #1;
        chk("sb_wb_busy", {31'h0, bus.rs2_busy}, 32'h0);
        chk("sb_wb_data", bus.rs2_data, 32'h55);
        chk("sb_vec_before_edge", bus.busy_vec, 32'h0000_0008);
        tick();
        idle();
        #1;
        chk("sb_vec_cleared", bus.busy_vec, 32'h0);
        chk("sb_data_stored", bus.rs2_data, 32'h55);

        // simultaneous set and clear on x9: set wins
        bus.issue_en = 1'b1; bus.issue_rd = 9;
        tick();
        bus.wb_en = 1'b1; bus.wb_rd = 9; bus.wb_data = 32'h1;
        tick();
        idle();
        bus.rs1_addr = 9;
        #1;
        chk("sim_busy_vec", bus.busy_vec, 32'h0000_0200);
        chk("sim_rs1_busy", {31'h0, bus.rs1_busy}, 32'h1);
        chk("sim_rs1_data", bus.rs1_data, 32'h1);
        tick();
        chk("sim_busy_persist", {31'h0, bus.rs1_busy}, 32'h1);
        bus.wb_en = 1'b1; bus.wb_rd = 9; bus.wb_data = 32'h2;
        #1;
        chk("sim_wb_clears", {31'h0, bus.rs1_busy}, 32'h0);
        tick();
        idle();
        #1;
        chk("sim_vec_zero", bus.busy_vec, 32'h0);
        chk("sim_x9_final", bus.rs1_data, 32'h2);

        // full sweep: issue x1..x31, drain x31..x1
        for (int i = 1; i < 32; i++) begin
            bus.issue_en = 1'b1;
            bus.issue_rd = 5'(i);
            tick();
        end
        idle();
        #1;
        chk("sweep_all_busy", bus.busy_vec, 32'hFFFF_FFFE);
        for (int i = 31; i >= 1; i--) begin
            bus.wb_en = 1'b1;
            bus.wb_rd = 5'(i);
            bus.wb_data = 32'h100 + 32'(i);
            tick();
            chk($sformatf("sweep_drain_%0d", i), bus.busy_vec, (32'h1 << i) - 32'h2);
        end
        idle();
        #1;
        chk("sweep_vec_zero", bus.busy_vec, 32'h0);
        for (int i = 1; i < 32; i++) begin
            bus.rs1_addr = 5'(i);
            bus.rs2_addr = 5'(32 - i);
            #1;
            chk($sformatf("sweep_rs1_x%0d", i), bus.rs1_data, 32'h100 + 32'(i));
            chk($sformatf("sweep_rs2_x%0d", 32 - i), bus.rs2_data, 32'h100 + 32'(32 - i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
